// File: rtl/ahb_slave_mem.sv
// AHB slave with word-organised on-chip memory.
// Byte/halfword/word access, configurable wait states, two-cycle ERROR response.
module ahb_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SLAVES_NUM  = 4,
    parameter int SLAVE_ID    = 0,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [$clog2(SLAVES_NUM)-1:0] HSEL,
    input  logic [ADDR_WIDTH-1:0]         HADDR,
    input  logic                          HWRITE,
    input  logic [2:0]                    HSIZE,
    input  logic [2:0]                    HBURST,
    input  logic [3:0]                    HPROT,
    input  logic [1:0]                    HTRANS,
    input  logic                          HREADY,
    input  logic [DATA_WIDTH-1:0]         HWDATA,
    output logic                          HREADYOUT,
    output logic                          HRESP,
    output logic [DATA_WIDTH-1:0]         HRDATA
);
    localparam int SW = $clog2(SLAVES_NUM);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam logic [SW-1:0] MY_ID = SW'(SLAVE_ID);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t                  state, nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [2:0]              size_q;
    logic [3:0]              cnt;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    open, accept, err, wr_active, wr_next;
    logic [IW-1:0]           idx_in, idx_q;
    logic [MW-1:0]           rd_idx;
    logic [3:0]              lanes_q;
    logic [DATA_WIDTH-1:0]   old_word, merged, rd_word;
    logic                    unused;

    function automatic logic [3:0] lane_mask(input logic [1:0] a,
                                             input logic [2:0] sz);
        logic [3:0] m;
        case (sz)
            3'd0:    m = 4'b0001 << a;
            3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    assign idx_in    = HADDR[ADDR_WIDTH-1:2];
    assign idx_q     = addr_q[ADDR_WIDTH-1:2];
    assign lanes_q   = lane_mask(addr_q[1:0], size_q);
    assign open      = (state == IDLE) || (state == DATA) || (state == ERR2);
    assign accept    = open && HREADY && (HSEL == MY_ID) && HTRANS[1];
    assign wr_active = (state == DATA) && write_q;
    assign wr_next   = (state == WAIT) ? write_q : HWRITE;
    assign unused    = ^{HBURST, HPROT, idx_q};

    assign err = (HSIZE > 3'd2)
              || (HSIZE == 3'd1 && HADDR[0])
              || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
              || (idx_in >= IW'(MEM_DEPTH));

    // Write-data merge; also forwarded to a read that overlaps the write's data phase
    always_comb begin
        old_word = mem[idx_q[MW-1:0]];
        merged   = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes_q[i]) merged[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    always_comb begin
        rd_idx = (state == WAIT) ? idx_q[MW-1:0] : idx_in[MW-1:0];
        if (wr_active && rd_idx == idx_q[MW-1:0]) rd_word = merged;
        else                                        rd_word = mem[rd_idx];
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, DATA, ERR2: begin
                if (!accept)        nxt = IDLE;
                else if (err)       nxt = ERR1;
                else if (WS != 4'd0) nxt = WAIT;
                else                nxt = DATA;
            end
            WAIT:    nxt = (cnt <= 4'd1) ? DATA : WAIT;
            ERR1:    nxt = ERR2;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            cnt       <= 4'd0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= 3'd0;
        end else begin
            state     <= nxt;
            HREADYOUT <= !(nxt == WAIT || nxt == ERR1);
            HRESP     <= (nxt == ERR1) || (nxt == ERR2);
            HRDATA    <= (nxt == DATA && !wr_next) ? rd_word : '0;
            if (accept) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
                cnt     <= WS;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Memory is intentionally not reset
    always_ff @(posedge HCLK) begin
        if (wr_active) mem[idx_q[MW-1:0]] <= merged;
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: three slaves on one bus
// (id0 W=0, id1 W=2, id2 W=3); HSEL=3 selects nobody.
module tb_ahb_slave_mem;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [1:0]  HSEL = 2'd0;
    logic [31:0] HADDR = 32'h0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd0;
    logic [2:0]  HBURST = 3'd0;
    logic [3:0]  HPROT = 4'd0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HREADY;
    logic [31:0] HWDATA = 32'h0;
    logic [2:0]  ro, rs;
    logic [31:0] rdv [3];

    typedef struct {
        int          id;
        bit          rd;
        logic [31:0] data;
        int          waits;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total = 0;
    int   nid = 0;

    assign HREADY = &ro;
    always #5 HCLK = ~HCLK;

    ahb_slave_mem #(.SLAVE_ID(0), .WAIT_STATES(0)) u_s0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(ro[0]), .HRESP(rs[0]), .HRDATA(rdv[0]));

    ahb_slave_mem #(.SLAVE_ID(1), .WAIT_STATES(2)) u_s1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(ro[1]), .HRESP(rs[1]), .HRDATA(rdv[1]));

    ahb_slave_mem #(.SLAVE_ID(2), .WAIT_STATES(3)) u_s2 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(ro[2]), .HRESP(rs[2]), .HRDATA(rdv[2]));

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic int wt(input logic [1:0] s);
        case (s)
            2'd1:    return 2;
            2'd2:    return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic rsp_m(input logic [1:0] s);
        case (s)
            2'd0:    return rs[0];
            2'd1:    return rs[1];
            2'd2:    return rs[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rd_m(input logic [1:0] s);
        case (s)
            2'd0:    return rdv[0];
            2'd1:    return rdv[1];
            2'd2:    return rdv[2];
            default: return 32'h0;
        endcase
    endfunction

    task automatic wait_accept();
        int n = 0;
        @(negedge HCLK);
        while (!HREADY) begin
            n++;
            if (n > 50) begin
                chk("accept timeout", 32'(HREADY), 32'h1);
                break;
            end
            @(negedge HCLK);
        end
        @(posedge HCLK);
        #1;
    endtask

    // d is write data for writes, expected HRDATA for reads
    task automatic xfer(input logic [1:0] sel, input logic w,
                        input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input bit e);
        exp_t x;
        x.id    = nid++;
        x.rd    = !w;
        x.data  = w ? 32'h0 : d;
        x.err   = e;
        x.waits = e ? 1 : wt(sel);
        exp_q.push_back(x);
        HSEL = sel; HADDR = a; HWRITE = w; HSIZE = sz; HTRANS = 2'b10;
        wait_accept();
        HWDATA = w ? d : 32'h0;
    endtask

    task automatic idle();
        HTRANS = 2'b00;
        wait_accept();
    endtask

    task automatic reset_checks(input string nm, input int i);
        chk({nm, " ready/resp"}, {30'h0, ro[i], rs[i]}, 32'h2);
        chk({nm, " rdata"}, rdv[i], 32'h0);
    endtask

    // Monitor: one pop per completed data phase
    initial begin
        bit         dp = 0;
        logic [1:0] ds = 2'd0;
        int         lows = 0;
        int         lowresp = 0;
        exp_t       e;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                dp = 0;
                continue;
            end
            if (dp) begin
                if (!HREADY) begin
                    lows++;
                    if (rsp_m(ds)) lowresp++;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected response", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("t%0d timing", e.id),
                        32'(lows * 65536 + lowresp * 2 + int'(rsp_m(ds))),
                        32'(e.waits * 65536 + (e.err ? e.waits : 0) * 2 + int'(e.err)));
                    if (e.rd)
                        chk($sformatf("t%0d rdata", e.id), rd_m(ds), e.data);
                end
            end
            if (HREADY) begin
                dp = HTRANS[1];
                ds = HSEL;
                lows = 0;
                lowresp = 0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge HCLK);
        #1;
        reset_checks("rst s0", 0);
        reset_checks("rst s1", 1);
        reset_checks("rst s2", 2);
        HRESETn = 1'b1;

        xfer(0, 1, 2, 32'h10, 32'hDEADBEEF, 0);
        idle();
        xfer(0, 0, 2, 32'h10, 32'hDEADBEEF, 0);
        idle();

        xfer(0, 1, 2, 32'h10, 32'h00000000, 0);
        xfer(0, 1, 0, 32'h11, 32'h0000AA00, 0);
        xfer(0, 1, 1, 32'h12, 32'h12340000, 0);
        idle();
        xfer(0, 0, 2, 32'h10, 32'h1234AA00, 0);
        xfer(0, 0, 0, 32'h13, 32'h1234AA00, 0);
        idle();

        xfer(1, 1, 2, 32'h20, 32'h0BADC0DE, 0);
        idle();
        xfer(1, 0, 2, 32'h20, 32'h0BADC0DE, 0);
        idle();

        xfer(0, 1, 2, 32'h30, 32'h11223344, 0);
        xfer(0, 0, 2, 32'h30, 32'h11223344, 0);
        xfer(0, 1, 0, 32'h31, 32'h00009900, 0);
        xfer(0, 0, 2, 32'h30, 32'h11229944, 0);
        idle();

        xfer(0, 1, 2, 32'h00, 32'h01020304, 0);
        idle();
        xfer(0, 1, 2, 32'h02, 32'hFFFFFFFF, 1);
        xfer(0, 1, 3, 32'h00, 32'hFFFFFFFF, 1);
        xfer(0, 1, 2, 32'h400, 32'hFFFFFFFF, 1);
        xfer(0, 1, 1, 32'h01, 32'hFFFFFFFF, 1);
        xfer(2, 1, 1, 32'h03, 32'hFFFFFFFF, 1);
        xfer(2, 0, 2, 32'h400, 32'h00000000, 1);
        xfer(3, 1, 2, 32'h00, 32'hAAAAAAAA, 0);
        xfer(1, 1, 2, 32'h00, 32'h55555555, 0);
        idle();
        xfer(0, 0, 2, 32'h00, 32'h01020304, 0);
        xfer(1, 0, 2, 32'h00, 32'h55555555, 0);
        idle();

        xfer(2, 1, 2, 32'h40, 32'hCAFEF00D, 0);
        idle();
        HSEL = 2'd2; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd2;
        HTRANS = 2'b10;
        wait_accept();
        HWDATA = 32'h12345678;
        HTRANS = 2'b00;
        @(negedge HCLK);
        @(negedge HCLK);
        chk("s2 mid-wait ready", 32'(ro[2]), 32'h0);
        #2 HRESETn = 1'b0;
        #1;
        reset_checks("abort s2", 2);
        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        xfer(2, 0, 2, 32'h40, 32'hCAFEF00D, 0);
        idle();

        repeat (3) @(negedge HCLK);
        chk("queue empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
